// File: rtl/multiplier_control_taint_track_bit.sv
// Controller for a shift-add multiplier that tracks one sticky taint bit
// alongside its state. Each control output has a companion *_t output.
// Latency is 2 + 2*WIDTH + popcount(multiplierReg) cycles from the start
// edge to productDone. start is ignored while busy.
//
// Ports:
//   clk, rst                        - clock and asynchronous active-high reset
//   start, start_t                  - multiply request and its taint
//   multiplierReg, multiplierReg_t  - multiplier value and per-bit taint
//   mdld, mrld, rsclear             - multiplicand load, multiplier load, result clear
//   rsload, rsshr                   - result add-load, result shift-right
//   productDone, busy               - completion pulse, in-operation flag
//   <output>_t                      - taint of each output (equal to state_t)
//
// Build option: define MULT_CTRL_EARLY_EXIT_EN to finish as soon as no set
// multiplier bits remain above the current bit.

module multiplier_control_taint_track_bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             mdld,
    output logic             mdld_t,
    output logic             mrld,
    output logic             mrld_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             productDone,
    output logic             productDone_t,
    output logic             busy,
    output logic             busy_t
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TEST,
        ADD,
        SHIFT,
        DONE
    } state_e;

    state_e        state;
    state_e        next_state;
    logic          state_t;
    logic          next_state_t;
    logic [CW-1:0] bitCounter;
    logic          bitCounter_t;
    logic          cnt_clr;
    logic          cnt_inc;

`ifdef MULT_CTRL_EARLY_EXIT_EN
    // Bits strictly above the current one; a shift by WIDTH yields zero,
    // so the last bit naturally reports "nothing left".
    logic [CW:0] upper_shamt;
    logic        upper_zero;
    logic        upper_t;

    assign upper_shamt = {1'b0, bitCounter} + 1'b1;
    assign upper_zero  = ((multiplierReg >> upper_shamt) == '0);
    assign upper_t     = |(multiplierReg_t >> upper_shamt);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            state_t      <= 1'b0;
            bitCounter   <= '0;
            bitCounter_t <= 1'b0;
        end else begin
            state   <= next_state;
            state_t <= next_state_t;
            // The counter's taint records the control taint at the moment it
            // was written, since that is what decided its new value.
            if (cnt_clr) begin
                bitCounter   <= '0;
                bitCounter_t <= state_t;
            end else if (cnt_inc) begin
                bitCounter   <= bitCounter + 1'b1;
                bitCounter_t <= state_t;
            end
        end
    end

    always_comb begin
        next_state   = state;
        next_state_t = state_t;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        mdld         = 1'b0;
        mrld         = 1'b0;
        rsclear      = 1'b0;
        rsload       = 1'b0;
        rsshr        = 1'b0;
        productDone  = 1'b0;

        case (state)
            IDLE: begin
                next_state_t = state_t | start_t;
                if (start) begin
                    next_state = INIT;
                end
            end
            INIT: begin
                mdld       = 1'b1;
                mrld       = 1'b1;
                rsclear    = 1'b1;
                cnt_clr    = 1'b1;
                next_state = TEST;
            end
            TEST: begin
                // The branch depends on a multiplier bit selected by the
                // counter, so both of their taints reach the control path.
                next_state_t = state_t | multiplierReg_t[bitCounter] | bitCounter_t;
                if (multiplierReg[bitCounter]) begin
                    next_state = ADD;
                end else begin
                    next_state = SHIFT;
                end
            end
            ADD: begin
                rsload     = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                rsshr   = 1'b1;
                cnt_inc = 1'b1;
`ifdef MULT_CTRL_EARLY_EXIT_EN
                next_state_t = state_t | upper_t | bitCounter_t;
                if (upper_zero) begin
                    next_state = DONE;
                end else begin
                    next_state = TEST;
                end
`else
                if (bitCounter == LAST_BIT) begin
                    next_state = DONE;
                end else begin
                    next_state = TEST;
                end
`endif
            end
            DONE: begin
                productDone = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Taint is a property of the control state as a whole, so every output
    // carries it whether or not that output is asserted.
    assign mdld_t        = state_t;
    assign mrld_t        = state_t;
    assign rsclear_t     = state_t;
    assign rsload_t      = state_t;
    assign rsshr_t       = state_t;
    assign productDone_t = state_t;
    assign busy_t        = state_t;

endmodule

// File: tb/tb_multiplier_control_taint_track_bit.sv
module tb_multiplier_control_taint_track_bit;

    localparam int W = 4;

    // Expected control vector {mdld,mrld,rsclear,rsload,rsshr,productDone,busy}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_INIT  = 7'b1110001;
    localparam logic [6:0] C_TEST  = 7'b0000001;
    localparam logic [6:0] C_ADD   = 7'b0001001;
    localparam logic [6:0] C_SHIFT = 7'b0000101;
    localparam logic [6:0] C_DONE  = 7'b0000011;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start_t;
    logic [W-1:0] multiplierReg;
    logic [W-1:0] multiplierReg_t;
    logic mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t;
    logic rsshr, rsshr_t, productDone, productDone_t, busy, busy_t;

    logic [6:0] ctl;
    logic [6:0] tv;
    assign ctl = {mdld, mrld, rsclear, rsload, rsshr, productDone, busy};
    assign tv  = {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t, productDone_t, busy_t};

    int passed = 0;
    int total  = 0;

    // Reference model state: expected per-cycle controls/taint of one operation
    logic [6:0] exp_ctl[$];
    logic       exp_t[$];
    logic       model_t = 1'b0;

    multiplier_control_taint_track_bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
        .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
        .rsclear(rsclear), .rsclear_t(rsclear_t), .rsload(rsload), .rsload_t(rsload_t),
        .rsshr(rsshr), .rsshr_t(rsshr_t), .productDone(productDone),
        .productDone_t(productDone_t), .busy(busy), .busy_t(busy_t)
    );

    always #5 clk = ~clk;

    // Builds the cycle-by-cycle expectation for one multiply: cycle 1 is INIT,
    // then per bit TEST [ADD] SHIFT, then DONE and one trailing IDLE cycle.
    // Taint is a sticky flag that turns on once any tainted value influences
    // a decision.
    task automatic model_op(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st);
        logic t;
        exp_ctl.delete();
        exp_t.delete();
        t = model_t | st;
        exp_ctl.push_back(C_INIT); exp_t.push_back(t);
        for (int i = 0; i < W; i++) begin
            exp_ctl.push_back(C_TEST); exp_t.push_back(t);
            t = t | mt[i];
            if (m[i]) begin
                exp_ctl.push_back(C_ADD); exp_t.push_back(t);
            end
            exp_ctl.push_back(C_SHIFT); exp_t.push_back(t);
`ifdef MULT_CTRL_EARLY_EXIT_EN
            t = t | (|(mt >> (i + 1)));
            if ((m >> (i + 1)) == 0) break;
`endif
        end
        exp_ctl.push_back(C_DONE); exp_t.push_back(t);
        exp_ctl.push_back(C_IDLE); exp_t.push_back(t);
        model_t = t;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        model_t = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_t = 1'b0;
        multiplierReg = '0; multiplierReg_t = '0;
        repeat (2) @(negedge clk);
        total++;
        if (ctl !== 7'b0 || tv !== 7'b0) begin
            $display("FAIL reset_state ctl=%b taint=%b required 0000000/0000000", ctl, tv);
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE || tv !== 7'b0) begin
            $display("FAIL idle_after_reset ctl=%b taint=%b required 0000000/0000000", ctl, tv);
        end else passed++;
    endtask

    // Runs one operation with the given inputs and compares every cycle.
    // Also measures the productDone cycle against an independent count.
    task automatic test_operation(input string name, input logic [W-1:0] m,
                                  input logic [W-1:0] mt, input logic st,
                                  input int done_cycle);
        int seen_done;
        model_op(m, mt, st);
        @(negedge clk);
        start = 1'b1; start_t = st; multiplierReg = m; multiplierReg_t = mt;
        seen_done = -1;
        for (int k = 0; k < exp_ctl.size(); k++) begin
            @(negedge clk);
            start = 1'b0; start_t = 1'b0;
            if (productDone === 1'b1) seen_done = k + 1;
            total++;
            if (ctl !== exp_ctl[k] || tv !== {7{exp_t[k]}}) begin
                $display("FAIL %s cycle %0d ctl=%b taint=%b required %b/%b",
                         name, k + 1, ctl, tv, exp_ctl[k], {7{exp_t[k]}});
            end else passed++;
        end
        if (done_cycle > 0) begin
            total++;
            if (seen_done != done_cycle) begin
                $display("FAIL %s_done_cycle got %0d required %0d", name, seen_done, done_cycle);
            end else passed++;
        end
    endtask

    task automatic test_directed();
        test_operation("clean_1010", 4'b1010, 4'b0000, 1'b0, 12);
        test_operation("taint_1010", 4'b1010, 4'b0100, 1'b0, 12);
        // Taint must survive the return to IDLE and into the next operation
        test_operation("sticky_0001", 4'b0001, 4'b0000, 1'b0, 0);
        pulse_reset();
        test_operation("start_taint", 4'b0110, 4'b0000, 1'b1, 0);
        pulse_reset();
    endtask

    task automatic test_early_exit();
`ifdef MULT_CTRL_EARLY_EXIT_EN
        test_operation("exit_0011", 4'b0011, 4'b0000, 1'b0, 8);
        test_operation("exit_0000", 4'b0000, 4'b0000, 1'b0, 4);
`else
        test_operation("exit_0011", 4'b0011, 4'b0000, 1'b0, 12);
        test_operation("exit_0000", 4'b0000, 4'b0000, 1'b0, 10);
`endif
        test_operation("full_1111", 4'b1111, 4'b0000, 1'b0, 14);
    endtask

    task automatic test_reset_mid_op();
        int seen_done;
        @(negedge clk);
        start = 1'b1; start_t = 1'b1; multiplierReg = 4'b1010; multiplierReg_t = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0; start_t = 1'b0;
        end
        total++;
        if (ctl !== C_ADD) begin
            $display("FAIL midrst_in_add ctl=%b required %b", ctl, C_ADD);
        end else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (ctl !== 7'b0 || tv !== 7'b0) begin
            $display("FAIL midrst_async ctl=%b taint=%b required 0000000/0000000", ctl, tv);
        end else passed++;
        // Release just before the edge with a fresh, untainted start pending
        #1 rst = 1'b0; start = 1'b1; start_t = 1'b0;
        model_t = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (ctl !== C_INIT || tv !== 7'b0) begin
            $display("FAIL midrst_restart ctl=%b taint=%b required %b/0000000", ctl, tv, C_INIT);
        end else passed++;
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (productDone === 1'b1) seen_done++;
        end
        total++;
        if (seen_done != 1 || busy !== 1'b0) begin
            $display("FAIL midrst_single_done pulses=%0d busy=%b required 1/0", seen_done, busy);
        end else passed++;
    endtask

    task automatic test_start_held();
        model_op(4'b1010, 4'b0000, 1'b0);
        @(negedge clk);
        start = 1'b1; start_t = 1'b0; multiplierReg = 4'b1010; multiplierReg_t = 4'b0000;
        for (int k = 0; k < exp_ctl.size(); k++) begin
            @(negedge clk);
            total++;
            if (ctl !== exp_ctl[k] || tv !== {7{exp_t[k]}}) begin
                $display("FAIL held_start cycle %0d ctl=%b taint=%b required %b/%b",
                         k + 1, ctl, tv, exp_ctl[k], {7{exp_t[k]}});
            end else passed++;
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (ctl !== C_INIT) begin
            $display("FAIL held_restart ctl=%b required %b", ctl, C_INIT);
        end else passed++;
        pulse_reset();
    endtask

    task automatic test_random();
        logic [W-1:0] m;
        logic [W-1:0] mt;
        logic         st;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                pulse_reset();
                total++;
                if (ctl !== 7'b0 || tv !== 7'b0) begin
                    $display("FAIL rand_reset op %0d ctl=%b taint=%b required 0", n, ctl, tv);
                end else passed++;
            end
            m  = W'($urandom);
            mt = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            st = ($urandom_range(0, 5) == 0);
            model_op(m, mt, st);
            @(negedge clk);
            start = 1'b1; start_t = st; multiplierReg = m; multiplierReg_t = mt;
            for (int k = 0; k < exp_ctl.size(); k++) begin
                @(negedge clk);
                start = 1'b0; start_t = 1'b0;
                total++;
                if (ctl !== exp_ctl[k] || tv !== {7{exp_t[k]}}) begin
                    $display("FAIL rand op %0d m=%b mt=%b cycle %0d ctl=%b taint=%b required %b/%b",
                             n, m, mt, k + 1, ctl, tv, exp_ctl[k], {7{exp_t[k]}});
                end else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_early_exit();
        pulse_reset();
        test_reset_mid_op();
        pulse_reset();
        test_start_held();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
